simon_game_ctrl: RTL and testbench

Parametrised, self-contained controller for the Simon memory game. It replaces the externally-counted state machine with one block. That block holds its own phase timer, user-response timer, score and step counters, and a reseedable LFSR sequence generator, and it supports a configurable light count, sequence length and timing. It sits between the switch inputs and the LED drivers of the game top level.

---
 rtl/simon_game_ctrl.sv | 178 +++++++++++++++++
 tb/tb_simon_game_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simon_game_ctrl.sv
// rtl/simon_game_ctrl.sv - Simon memory game controller with internal timers, score and LFSR sequence
module simon_game_ctrl #(
    parameter int          N_LIGHTS    = 4,
    parameter int          MAX_LEN     = 16,
    parameter int          SHOW_CYC    = 50,
    parameter int          GAP_CYC     = 25,
    parameter int          USER_TO_CYC = 500,
    parameter logic [15:0] SEED        = 16'hACE1,
    localparam int         IDX_W       = $clog2(N_LIGHTS),
    localparam int         SCORE_W     = $clog2(MAX_LEN + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [N_LIGHTS-1:0] sw,
    output logic [N_LIGHTS-1:0] lights,
    output logic                simons_turn,
    output logic                fini,
    output logic                win,
    output logic [SCORE_W-1:0]  score
);

    // One shared timer serves every timed state, so it must hold the largest count.
    localparam int T_MAX0 = (SHOW_CYC > GAP_CYC) ? SHOW_CYC : GAP_CYC;
    localparam int T_MAX  = (T_MAX0 > USER_TO_CYC) ? T_MAX0 : USER_TO_CYC;
    localparam int TMR_W  = $clog2(T_MAX);

    typedef enum logic [2:0] {
        IDLE, IDLE_PAUSE, PLAY, PLAY_PAUSE, REC, REC_WAIT, FAIL, WIN
    } stateT;

    stateT              state;
    stateT              nextState;
    logic [15:0]        freeCnt;
    logic [15:0]        gameSeed;
    logic [15:0]        lfsr;
    logic [TMR_W-1:0]   timer;
    logic [SCORE_W-1:0] step;

    logic [15:0]         lfsrNext;
    logic [15:0]         seedRaw;
    logic [15:0]         seedNew;
    logic [IDX_W-1:0]    expIdx;
    logic [N_LIGHTS-1:0] expected;
    logic [SCORE_W-1:0]  scoreInc;
    logic                showDone;
    logic                gapDone;
    logic                userTimeout;
    logic                stepLast;

    // Derived values: sequence position, seed candidate and phase-timer expiry flags.
    always_comb begin
        lfsrNext    = (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 16'h0000);
        seedRaw     = freeCnt ^ SEED;
        seedNew     = (seedRaw == 16'h0000) ? SEED : seedRaw;
        expIdx      = lfsr[IDX_W-1:0];
        expected    = N_LIGHTS'(1) << expIdx;
        scoreInc    = score + SCORE_W'(1);
        showDone    = (timer == TMR_W'(SHOW_CYC - 1));
        gapDone     = (timer == TMR_W'(GAP_CYC - 1));
        userTimeout = (timer == TMR_W'(USER_TO_CYC - 1));
        stepLast    = (step == score);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state decision; a matching press outranks the timeout in the same cycle.
    always_comb begin
        nextState = state;
        case (state)
            IDLE, FAIL, WIN: if (start) nextState = IDLE_PAUSE;
            IDLE_PAUSE:      if (gapDone) nextState = PLAY;
            PLAY:            if (showDone) nextState = PLAY_PAUSE;
            PLAY_PAUSE:      if (gapDone) nextState = stepLast ? REC : PLAY;
            REC: begin
                if (sw == expected)        nextState = REC_WAIT;
                else if (sw != '0)         nextState = FAIL;
                else if (userTimeout)      nextState = FAIL;
            end
            REC_WAIT: begin
                if (sw == '0) begin
                    if (!stepLast)                           nextState = REC;
                    else if (scoreInc == SCORE_W'(MAX_LEN))  nextState = WIN;
                    else                                     nextState = IDLE_PAUSE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // Datapath: free counter, seed capture, sequence LFSR, phase timer, step and score.
    always_ff @(posedge clk) begin
        if (rst) begin
            freeCnt  <= '0;
            gameSeed <= SEED;
            lfsr     <= SEED;
            timer    <= '0;
            step     <= '0;
            score    <= '0;
        end else begin
            freeCnt <= freeCnt + 16'd1;

            if (nextState != state) begin
                timer <= '0;
            end else if (state inside {IDLE_PAUSE, PLAY, PLAY_PAUSE, REC}) begin
                timer <= timer + TMR_W'(1);
            end

            case (state)
                IDLE, FAIL, WIN: begin
                    if (start) begin
                        gameSeed <= seedNew;
                        score    <= '0;
                    end
                end
                IDLE_PAUSE: begin
                    if (gapDone) begin
                        lfsr <= gameSeed;
                        step <= '0;
                    end
                end
                PLAY_PAUSE: begin
                    if (gapDone) begin
                        if (stepLast) begin
                            lfsr <= gameSeed;
                            step <= '0;
                        end else begin
                            lfsr <= lfsrNext;
                            step <= step + SCORE_W'(1);
                        end
                    end
                end
                REC_WAIT: begin
                    if (sw == '0) begin
                        if (stepLast) begin
                            score <= scoreInc;
                        end else begin
                            lfsr <= lfsrNext;
                            step <= step + SCORE_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Moore outputs per state; during recall the LEDs mirror the switches directly.
    always_comb begin
        lights      = '0;
        simons_turn = 1'b0;
        fini        = 1'b0;
        win         = 1'b0;
        case (state)
            IDLE:             lights = '1;
            PLAY: begin
                lights      = expected;
                simons_turn = 1'b1;
            end
            PLAY_PAUSE:       simons_turn = 1'b1;
            REC, REC_WAIT:    lights = sw;
            FAIL:             fini = 1'b1;
            WIN: begin
                lights = '1;
                win    = 1'b1;
            end
            default:          lights = '0;
        endcase
    end

endmodule

// File: tb/tb_simon_game_ctrl.sv
// tb/tb_simon_game_ctrl.sv - randomized self-checking bench for simon_game_ctrl
module tb_simon_game_ctrl;

    localparam int          NL = 4;
    localparam int          ML = 3;
    localparam int          SC = 4;
    localparam int          GC = 2;
    localparam int          UT = 10;
    localparam logic [15:0] SD = 16'hACE1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] sw = 4'b0000;
    logic [3:0] lights;
    logic       simonsTurn;
    logic       fini;
    logic       win;
    logic [1:0] score;

    simon_game_ctrl #(
        .N_LIGHTS(NL), .MAX_LEN(ML), .SHOW_CYC(SC), .GAP_CYC(GC),
        .USER_TO_CYC(UT), .SEED(SD)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .sw(sw), .lights(lights),
        .simons_turn(simonsTurn), .fini(fini), .win(win), .score(score)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Game-level model: a whole round of showing is one timed span, the sequence is a table.
    typedef enum {M_IDLE, M_GAP, M_SHOW, M_RECALL, M_LOST, M_WON} modeT;
    modeT        mMode = M_IDLE;
    int          mTime = 0;
    int          mStep = 0;
    int          mScore = 0;
    bit          mHeld = 0;
    logic [15:0] mCnt = 16'h0000;
    logic [15:0] mSeed = 16'h0000;
    int          mSeq[ML];
    bit          modelValid = 0;

    function automatic logic [15:0] lfsrAdv(input logic [15:0] l);
        return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [3:0] oneHot(input int idx);
        return 4'(1 << idx);
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update on each rising edge from the same inputs the DUT samples.
    always @(posedge clk) begin : modelProc
        logic [15:0] s;
        if (rst) begin
            mMode = M_IDLE; mTime = 0; mStep = 0; mScore = 0; mHeld = 0;
            mCnt = 16'h0000; modelValid = 1;
        end else begin
            case (mMode)
                M_IDLE, M_LOST, M_WON: begin
                    if (start) begin
                        s = mCnt ^ SD;
                        if (s == 16'h0000) s = SD;
                        mSeed = s;
                        for (int k = 0; k < ML; k++) begin
                            mSeq[k] = int'(s[1:0]);
                            s = lfsrAdv(s);
                        end
                        mMode = M_GAP; mTime = 0; mScore = 0;
                    end
                end
                M_GAP: begin
                    if (mTime == GC - 1) begin mMode = M_SHOW; mTime = 0; end
                    else mTime++;
                end
                M_SHOW: begin
                    if (mTime == (mScore + 1) * (SC + GC) - 1) begin
                        mMode = M_RECALL; mTime = 0; mStep = 0; mHeld = 0;
                    end else mTime++;
                end
                M_RECALL: begin
                    if (!mHeld) begin
                        if (sw == oneHot(mSeq[mStep])) mHeld = 1;
                        else if (sw != 4'b0000)         mMode = M_LOST;
                        else if (mTime == UT - 1)       mMode = M_LOST;
                        else                            mTime++;
                    end else if (sw == 4'b0000) begin
                        if (mStep == mScore) begin
                            mScore++;
                            mMode = (mScore == ML) ? M_WON : M_GAP;
                            mTime = 0;
                        end else begin
                            mStep++; mHeld = 0; mTime = 0;
                        end
                    end
                end
                default: ;
            endcase
            mCnt = mCnt + 16'd1;
        end
    end

    // Every-cycle comparison of all outputs against the model, away from the active edge.
    always @(negedge clk) begin : cmpProc
        logic [3:0] eL;
        logic       eT, eF, eW;
        int         k, w;
        if (modelValid) begin
            eL = 4'b0000; eT = 0; eF = 0; eW = 0;
            case (mMode)
                M_IDLE:   eL = 4'b1111;
                M_SHOW: begin
                    eT = 1;
                    k = mTime / (SC + GC);
                    w = mTime % (SC + GC);
                    if (w < SC) eL = oneHot(mSeq[k]);
                end
                M_RECALL: eL = sw;
                M_LOST:   eF = 1;
                M_WON: begin eL = 4'b1111; eW = 1; end
                default: ;
            endcase
            check("cyc_lights", 16'(lights), 16'(eL));
            check("cyc_turn", 16'(simonsTurn), 16'(eT));
            check("cyc_fini", 16'(fini), 16'(eF));
            check("cyc_win", 16'(win), 16'(eW));
            check("cyc_score", 16'(score), 16'(mScore));
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic waitMode(input modeT m, input int maxC);
        int c;
        c = 0;
        while (mMode != m && c < maxC) begin
            tick(1);
            c++;
        end
        if (mMode != m) begin
            checks++;
            errors++;
            $display("FAIL wait_mode: still in %s after %0d cycles, wanted %s", mMode.name(), maxC, m.name());
        end
    endtask

    // One recall step: 0 correct, 1 wrong press, 2 timeout, 3 correct on the last allowed cycle.
    task automatic doStep(input int action);
        logic [3:0] exp, bad;
        exp = oneHot(mSeq[mStep]);
        case (action)
            1: begin
                tick($urandom_range(0, UT - 2));
                do bad = 4'($urandom_range(1, 15)); while (bad == exp);
                sw = bad;
                tick(1);
                sw = 4'b0000;
            end
            2: tick(UT);
            default: begin
                tick((action == 3) ? UT - 1 : $urandom_range(0, UT - 2));
                sw = exp;
                tick($urandom_range(1, 3));
                if ($urandom_range(0, 1) == 1) begin
                    sw = 4'($urandom_range(1, 15));
                    tick($urandom_range(1, 2));
                end
                sw = 4'b0000;
                tick(1);
            end
        endcase
    endtask

    task automatic playRound();
        int r;
        waitMode(M_RECALL, 400);
        r = mScore;
        for (int k = 0; k <= r; k++) doStep(0);
    endtask

    task automatic pulseStart();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard, a;
        check("pin_lfsr1", lfsrAdv(16'hACE1), 16'hE270);
        check("pin_lfsr2", lfsrAdv(16'hE270), 16'h7138);

        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        check("rst_lights", 16'(lights), 16'h000F);
        check("rst_score", 16'(score), 16'h0000);
        check("rst_fini", 16'(fini), 16'h0000);
        check("rst_win", 16'(win), 16'h0000);
        check("rst_turn", 16'(simonsTurn), 16'h0000);

        // Game 1: start at free count 0 so the seed is exactly the base seed.
        pulseStart();
        check("g1_gap1_lights", 16'(lights), 16'h0000);
        tick(1);
        check("g1_gap2_lights", 16'(lights), 16'h0000);
        check("g1_gap2_turn", 16'(simonsTurn), 16'h0000);
        tick(1);
        check("g1_show_turn", 16'(simonsTurn), 16'h0001);
        check("g1_show_light", 16'(lights), 16'h0002);
        tick(SC);
        check("g1_pause_lights", 16'(lights), 16'h0000);
        check("g1_pause_turn", 16'(simonsTurn), 16'h0001);
        tick(GC);
        check("g1_rec_turn", 16'(simonsTurn), 16'h0000);
        playRound();
        check("g1_score1", 16'(score), 16'h0001);
        waitMode(M_SHOW, 20);
        check("g1_r2_first", 16'(lights), 16'h0002);
        tick(SC + GC);
        check("g1_r2_second", 16'(lights), 16'h0001);
        playRound();
        playRound();
        tick(1);
        check("g1_win", 16'(win), 16'h0001);
        check("g1_win_score", 16'(score), 16'h0003);
        check("g1_win_lights", 16'(lights), 16'h000F);
        repeat (6) begin
            sw = 4'($urandom_range(0, 15));
            tick(1);
        end
        sw = 4'b0000;
        check("g1_win_hold", 16'(win), 16'h0001);

        // Game 2: a wrong press in round two.
        tick($urandom_range(0, 30));
        pulseStart();
        playRound();
        waitMode(M_RECALL, 400);
        doStep(1);
        check("g2_fini", 16'(fini), 16'h0001);
        check("g2_lights", 16'(lights), 16'h0000);
        check("g2_score_hold", 16'(score), 16'h0001);
        tick(2);
        pulseStart();
        check("g3_restart_score", 16'(score), 16'h0000);
        check("g3_restart_fini", 16'(fini), 16'h0000);

        // Game 3: no press at all.
        waitMode(M_RECALL, 400);
        tick(UT - 1);
        check("g3_before_to", 16'(fini), 16'h0000);
        tick(1);
        check("g3_timeout", 16'(fini), 16'h0001);

        // Game 4: press on the final allowed cycle, then a mid-show reset in round three.
        pulseStart();
        waitMode(M_RECALL, 400);
        tick(UT - 1);
        sw = oneHot(mSeq[0]);
        tick(1);
        check("g4_late_press", 16'(fini), 16'h0000);
        sw = 4'b0000;
        tick(1);
        check("g4_score1", 16'(score), 16'h0001);
        playRound();
        waitMode(M_SHOW, 20);
        tick(2 * (SC + GC) + 1);
        check("g4_step2_turn", 16'(simonsTurn), 16'h0001);
        rst = 1'b1;
        tick(1);
        check("g4_rst_lights", 16'(lights), 16'h000F);
        check("g4_rst_score", 16'(score), 16'h0000);
        check("g4_rst_turn", 16'(simonsTurn), 16'h0000);
        rst = 1'b0;
        tick(2);

        // Random games with mixed outcomes and ignored start pulses.
        repeat (6) begin
            tick($urandom_range(0, 40));
            pulseStart();
            guard = 0;
            while (mMode != M_LOST && mMode != M_WON && guard < 40) begin
                if ((mMode == M_GAP || mMode == M_SHOW) && $urandom_range(0, 3) == 0) begin
                    waitMode(M_SHOW, 20);
                    pulseStart();
                end
                waitMode(M_RECALL, 400);
                if (mMode == M_RECALL) begin
                    a = $urandom_range(0, 99);
                    doStep(a < 80 ? 0 : (a < 88 ? 1 : (a < 94 ? 2 : 3)));
                end
                guard++;
            end
            tick(2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
